// File: rtl/memwb_pkg.sv
// Shared types and constants for the MEM->WB skid stage: state encoding and occupancy codes.
package memwb_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_FULL  = 2'd1;
  localparam logic [1:0] OCC_SKID  = 2'd2;

  function automatic logic [1:0] occ_of(state_t s);
    case (s)
      FULL:    return OCC_FULL;
      SKID:    return OCC_SKID;
      default: return OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/memwb_payload_reg.sv
// Enable-loaded payload register with asynchronous active-low clear.
module memwb_payload_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  q_o <= '0;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/memwb_skid_stage.sv
// MEM->WB pipeline stage with valid/ready handshake, one-entry skid buffer and synchronous flush.
// Optional: define MEMWB_X0_SUPPRESS_EN to gate RegWrite_o off when the destination is x0.
module memwb_skid_stage
  import memwb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned WB_W   = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [WB_W-1:0]   WB_i,
  input  logic [DATA_W-1:0] Data_i,
  input  logic [DATA_W-1:0] ALUout_i,
  input  logic [RD_W-1:0]   RDaddr_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [DATA_W-1:0] Data_o,
  output logic [DATA_W-1:0] ALUout_o,
  output logic [RD_W-1:0]   RDaddr_o,
  output logic [1:0]        occ_o
);

  localparam int unsigned PAYLOAD_W = WB_W + 2 * DATA_W + RD_W;

  state_t                 state_q, state_d;
  logic                   accept, take;
  logic                   main_en, skid_en, main_from_skid;
  logic [PAYLOAD_W-1:0]   in_pl, main_d, main_q, skid_q;

  assign in_pl   = {WB_i, Data_i, ALUout_i, RDaddr_i};
  assign ready_o = (state_q != SKID);
  assign valid_o = (state_q != EMPTY);
  assign accept  = valid_i & ready_o;
  assign take    = valid_o & ready_i;
  assign main_d  = main_from_skid ? skid_q : in_pl;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  // Flush overrides every transition and suppresses all payload loads that cycle.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_en = 1'b1;
            state_d = FULL;
          end
        end
        FULL: begin
          if (accept && take) begin
            main_en = 1'b1;
          end else if (accept) begin
            skid_en = 1'b1;
            state_d = SKID;
          end else if (take) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (take) begin
            main_en        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  memwb_payload_reg #(.W(PAYLOAD_W)) u_main (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (main_en),
    .d_i     (main_d),
    .q_o     (main_q)
  );

  memwb_payload_reg #(.W(PAYLOAD_W)) u_skid (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (skid_en),
    .d_i     (in_pl),
    .q_o     (skid_q)
  );

  assign Data_o     = main_q[2*DATA_W+RD_W-1 -: DATA_W];
  assign ALUout_o   = main_q[DATA_W+RD_W-1 -: DATA_W];
  assign RDaddr_o   = main_q[RD_W-1:0];
  assign MemtoReg_o = main_q[PAYLOAD_W-WB_W];
  assign occ_o      = occ_of(state_q);

`ifdef MEMWB_X0_SUPPRESS_EN
  assign RegWrite_o = valid_o & main_q[PAYLOAD_W-1] & (|RDaddr_o);
`else
  assign RegWrite_o = valid_o & main_q[PAYLOAD_W-1];
`endif

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Self-checking bench for memwb_skid_stage: directed table, reset/flush/param sequences, random vs queue model.
module tb_memwb_skid_stage;

`ifdef MEMWB_X0_SUPPRESS_EN
  localparam bit X0_SUP = 1'b1;
`else
  localparam bit X0_SUP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        flush_i, valid_i, ready_i;
  logic [1:0]  WB_i;
  logic [31:0] Data_i, ALUout_i;
  logic [4:0]  RDaddr_i;
  logic        ready_o, valid_o, RegWrite_o, MemtoReg_o;
  logic [31:0] Data_o, ALUout_o;
  logic [4:0]  RDaddr_o;
  logic [1:0]  occ_o;

  logic        flush64, valid64, ready64;
  logic [2:0]  wb64;
  logic [63:0] data64, alu64;
  logic [5:0]  rd64;
  logic        ready_o64, valid_o64, rw_o64, m2r_o64;
  logic [63:0] data_o64, alu_o64;
  logic [5:0]  rd_o64;
  logic [1:0]  occ_o64;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  memwb_skid_stage dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .WB_i(WB_i), .Data_i(Data_i), .ALUout_i(ALUout_i), .RDaddr_i(RDaddr_i),
    .valid_o(valid_o), .ready_i(ready_i), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .Data_o(Data_o), .ALUout_o(ALUout_o), .RDaddr_o(RDaddr_o), .occ_o(occ_o)
  );

  memwb_skid_stage #(.DATA_W(64), .RD_W(6), .WB_W(3)) dut64 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush64), .valid_i(valid64), .ready_o(ready_o64),
    .WB_i(wb64), .Data_i(data64), .ALUout_i(alu64), .RDaddr_i(rd64),
    .valid_o(valid_o64), .ready_i(ready64), .RegWrite_o(rw_o64), .MemtoReg_o(m2r_o64),
    .Data_o(data_o64), .ALUout_o(alu_o64), .RDaddr_o(rd_o64), .occ_o(occ_o64)
  );

  typedef struct {
    logic v, r, f;
    logic [1:0] wb;
    logic [31:0] data, alu;
    logic [4:0] rd;
    logic ev;
    logic [1:0] eocc;
    logic erdy, erw, em2r;
    logic [31:0] edata, ealu;
    logic [4:0] erd;
  } vec_t;

  typedef struct {
    logic [1:0] wb;
    logic [31:0] data, alu;
    logic [4:0] rd;
  } pl_t;

  vec_t tbl[16];
  pl_t  mq[$];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic v, logic r, logic f, logic [1:0] wb, logic [31:0] d, logic [31:0] a,
                              logic [4:0] rd, logic ev, logic [1:0] eocc, logic erdy, logic erw,
                              logic em2r, logic [31:0] ed, logic [31:0] ea, logic [4:0] erd);
    vec_t t;
    t.v = v; t.r = r; t.f = f; t.wb = wb; t.data = d; t.alu = a; t.rd = rd;
    t.ev = ev; t.eocc = eocc; t.erdy = erdy; t.erw = erw; t.em2r = em2r;
    t.edata = ed; t.ealu = ea; t.erd = erd;
    return t;
  endfunction

  task automatic drive(input logic v, input logic r, input logic f, input logic [1:0] wb,
                       input logic [31:0] d, input logic [31:0] a, input logic [4:0] rd);
    valid_i = v; ready_i = r; flush_i = f; WB_i = wb; Data_i = d; ALUout_i = a; RDaddr_i = rd;
  endtask

  task automatic check_model(input string tag);
    cmp({tag, ".valid"}, 64'(valid_o), 64'(mq.size() > 0));
    cmp({tag, ".occ"},   64'(occ_o),   64'(mq.size()));
    cmp({tag, ".ready"}, 64'(ready_o), 64'(mq.size() != 2));
    if (mq.size() > 0) begin
      cmp({tag, ".rw"},   64'(RegWrite_o), 64'(mq[0].wb[1] & !(X0_SUP && mq[0].rd == 0)));
      cmp({tag, ".m2r"},  64'(MemtoReg_o), 64'(mq[0].wb[0]));
      cmp({tag, ".data"}, 64'(Data_o),     64'(mq[0].data));
      cmp({tag, ".alu"},  64'(ALUout_o),   64'(mq[0].alu));
      cmp({tag, ".rd"},   64'(RDaddr_o),   64'(mq[0].rd));
    end else begin
      cmp({tag, ".rw"}, 64'(RegWrite_o), 64'd0);
    end
  endtask

  initial begin
    logic rw14;
    rw14 = !X0_SUP;
    tbl[0]  = mk(1,1,0,2'b10,32'h100,32'h10,5'd1,  1,2'd1,1,1,0,32'h100,32'h10,5'd1);
    tbl[1]  = mk(1,1,0,2'b10,32'h101,32'h11,5'd2,  1,2'd1,1,1,0,32'h101,32'h11,5'd2);
    tbl[2]  = mk(1,1,0,2'b10,32'h102,32'h12,5'd3,  1,2'd1,1,1,0,32'h102,32'h12,5'd3);
    tbl[3]  = mk(1,1,0,2'b10,32'h103,32'h13,5'd4,  1,2'd1,1,1,0,32'h103,32'h13,5'd4);
    tbl[4]  = mk(0,1,0,2'b00,32'h0,  32'h0, 5'd0,  0,2'd0,1,0,0,32'h0,  32'h0, 5'd0);
    tbl[5]  = mk(1,0,0,2'b10,32'h105,32'h15,5'd5,  1,2'd1,1,1,0,32'h105,32'h15,5'd5);
    tbl[6]  = mk(1,0,0,2'b10,32'h106,32'h16,5'd6,  1,2'd2,0,1,0,32'h105,32'h15,5'd5);
    tbl[7]  = mk(1,0,0,2'b11,32'h1FF,32'h1F,5'h1F, 1,2'd2,0,1,0,32'h105,32'h15,5'd5);
    tbl[8]  = mk(0,1,0,2'b00,32'h0,  32'h0, 5'd0,  1,2'd1,1,1,0,32'h106,32'h16,5'd6);
    tbl[9]  = mk(0,1,0,2'b00,32'h0,  32'h0, 5'd0,  0,2'd0,1,0,0,32'h0,  32'h0, 5'd0);
    tbl[10] = mk(1,0,0,2'b10,32'h108,32'h18,5'd8,  1,2'd1,1,1,0,32'h108,32'h18,5'd8);
    tbl[11] = mk(1,0,0,2'b10,32'h109,32'h19,5'd9,  1,2'd2,0,1,0,32'h108,32'h18,5'd8);
    tbl[12] = mk(1,0,1,2'b10,32'h107,32'h17,5'd7,  0,2'd0,1,0,0,32'h0,  32'h0, 5'd0);
    tbl[13] = mk(0,1,0,2'b00,32'h0,  32'h0, 5'd0,  0,2'd0,1,0,0,32'h0,  32'h0, 5'd0);
    tbl[14] = mk(1,0,0,2'b11,32'hDEADBEEF,32'h55,5'd0, 1,2'd1,1,rw14,1,32'hDEADBEEF,32'h55,5'd0);
    tbl[15] = mk(0,1,0,2'b00,32'h0,  32'h0, 5'd0,  0,2'd0,1,0,0,32'h0,  32'h0, 5'd0);

    rst_n_i = 1'b0;
    drive(0, 0, 0, '0, '0, '0, '0);
    flush64 = 0; valid64 = 0; ready64 = 0; wb64 = '0; data64 = '0; alu64 = '0; rd64 = '0;
    #12;
    cmp("rst.valid", 64'(valid_o), 0);    cmp("rst.ready", 64'(ready_o), 1);
    cmp("rst.occ", 64'(occ_o), 0);        cmp("rst.rw", 64'(RegWrite_o), 0);
    cmp("rst.m2r", 64'(MemtoReg_o), 0);   cmp("rst.data", 64'(Data_o), 0);
    cmp("rst.alu", 64'(ALUout_o), 0);     cmp("rst.rd", 64'(RDaddr_o), 0);
    cmp("rst64.valid", 64'(valid_o64), 0); cmp("rst64.data", data_o64, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].wb, tbl[i].data, tbl[i].alu, tbl[i].rd);
      @(posedge clk_i);
      @(negedge clk_i);
      cmp($sformatf("v%0d.valid", i), 64'(valid_o), 64'(tbl[i].ev));
      cmp($sformatf("v%0d.occ", i),   64'(occ_o),   64'(tbl[i].eocc));
      cmp($sformatf("v%0d.ready", i), 64'(ready_o), 64'(tbl[i].erdy));
      cmp($sformatf("v%0d.rw", i),    64'(RegWrite_o), 64'(tbl[i].erw));
      if (tbl[i].ev) begin
        cmp($sformatf("v%0d.m2r", i),  64'(MemtoReg_o), 64'(tbl[i].em2r));
        cmp($sformatf("v%0d.data", i), 64'(Data_o),     64'(tbl[i].edata));
        cmp($sformatf("v%0d.alu", i),  64'(ALUout_o),   64'(tbl[i].ealu));
        cmp($sformatf("v%0d.rd", i),   64'(RDaddr_o),   64'(tbl[i].erd));
      end
    end

    // Asynchronous reset mid-cycle while holding an entry.
    drive(1, 0, 0, 2'b11, 32'hCAFE0001, 32'h77, 5'd21);
    @(posedge clk_i);
    #2;
    drive(0, 0, 0, '0, '0, '0, '0);
    cmp("arst.pre_valid", 64'(valid_o), 1);
    rst_n_i = 1'b0;
    #1;
    cmp("arst.valid", 64'(valid_o), 0);  cmp("arst.ready", 64'(ready_o), 1);
    cmp("arst.occ", 64'(occ_o), 0);      cmp("arst.rw", 64'(RegWrite_o), 0);
    cmp("arst.m2r", 64'(MemtoReg_o), 0); cmp("arst.data", 64'(Data_o), 0);
    cmp("arst.alu", 64'(ALUout_o), 0);   cmp("arst.rd", 64'(RDaddr_o), 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Wide parameter set.
    valid64 = 1; ready64 = 0; wb64 = 3'b101;
    data64 = 64'h0123_4567_89AB_CDEF; alu64 = 64'hFEDC_BA98_7654_3210; rd64 = 6'h2A;
    @(posedge clk_i);
    @(negedge clk_i);
    valid64 = 0;
    cmp("w64.valid", 64'(valid_o64), 1); cmp("w64.rw", 64'(rw_o64), 1);
    cmp("w64.m2r", 64'(m2r_o64), 1);     cmp("w64.data", data_o64, 64'h0123_4567_89AB_CDEF);
    cmp("w64.alu", alu_o64, 64'hFEDC_BA98_7654_3210);
    cmp("w64.rd", 64'(rd_o64), 64'h2A);  cmp("w64.occ", 64'(occ_o64), 1);

    // Random traffic against a two-deep FIFO model.
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      pl_t p;
      logic v, r, f, acc, tk;
      p.wb = 2'($urandom); p.data = $urandom; p.alu = $urandom;
      p.rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      v = 1'($urandom); r = ($urandom_range(0, 2) != 0); f = ($urandom_range(0, 19) == 0);
      drive(v, r, f, p.wb, p.data, p.alu, p.rd);
      acc = v && (mq.size() != 2);
      tk  = r && (mq.size() > 0);
      if (f) mq.delete();
      else begin
        if (tk) void'(mq.pop_front());
        if (acc) mq.push_back(p);
      end
      @(posedge clk_i);
      @(negedge clk_i);
      check_model($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memwb_skid_stage.md
# memwb_skid_stage

Parametrised MEM→WB pipeline stage register with valid/ready flow control, a one-entry skid buffer, and synchronous flush. It sits between the data-memory stage and register-file write-back. It replaces the free-running stage register so that a write-back stall does not drop or duplicate instructions, and so that a squashed instruction never produces a register write. Payload widths are parameters; outputs are decoded exactly as the core expects.

## Interface
- DATA_W, 32, width of memory read data and ALU result
- RD_W, 5, destination register address width
- WB_W, 2, write-back control width (≥2); bit WB_W-1 = RegWrite, bit 0 = MemtoReg
- clk_i  input  1  clock, rising edge
- rst_n_i  input  1  reset; one clock, reset asynchronous and active-low
- flush_i  input  1  synchronous squash of all held entries
- valid_i  input  1  upstream entry valid
- ready_o  output  1  stage can accept this cycle
- WB_i  input  WB_W  write-back control
- Data_i  input  DATA_W  memory read data
- ALUout_i  input  DATA_W  ALU result
- RDaddr_i  input  RD_W  destination register
- valid_o  output  1  output entry valid
- ready_i  input  1  write-back consumes output this cycle
- RegWrite_o  output  1  qualified register write enable
- MemtoReg_o  output  1  write-back mux select
- Data_o  output  DATA_W  held memory data
- ALUout_o  output  DATA_W  held ALU result
- RDaddr_o  output  RD_W  held destination address
- occ_o  output  2  entries held (0..2)

## Operation
- Two payload registers: main (drives outputs) and skid. State register with states EMPTY, FULL, SKID.
- ready_o = (state != SKID), decoded from the registered state only, with no combinational path from ready_i. accept = valid_i & ready_o. take = valid_o & ready_i.
- EMPTY: accept → main←in, FULL.
- FULL: accept & take → main←in, stay FULL. accept & !take → skid←in, SKID. !accept & take → EMPTY. Otherwise hold.
- SKID: take → main←skid, FULL. Otherwise hold. No accept is possible in SKID.
- flush_i has priority over every transition: next state EMPTY, and the input presented that cycle is discarded. Payload registers are not required to clear.
- valid_o = (state != EMPTY). occ_o: EMPTY=0, FULL=1, SKID=2.
- RegWrite_o = valid_o & mainWB[WB_W-1]. MemtoReg_o = mainWB[0], ungated. Data, ALUout and RDaddr outputs are raw main contents.
- Payload is never altered in flight. Order is strictly FIFO.

## Timing
- Reset (asserted asynchronously): state EMPTY; all payload registers 0; valid_o=0, RegWrite_o=0, MemtoReg_o=0, Data_o=0, ALUout_o=0, RDaddr_o=0, occ_o=0, ready_o=1.
- Reset asserted mid-operation drops all entries immediately. Deassertion is synchronised externally.
- Latency: entry accepted at edge N appears on outputs with valid_o=1 after edge N.
- Throughput: 1 entry per cycle while ready_i=1.
- Entries enter the skid register only when ready_i is low. ready_o drops in the cycle after the skid fills, and returns one cycle after the first take out of SKID.
- flush_i and take in the same cycle: the flush wins, and the write-back may still sample the current outputs that cycle.

## Configuration
- MEMWB_X0_SUPPRESS_EN defined: RegWrite_o additionally forced 0 when RDaddr_o == 0, so x0 is never written regardless of control bits.
- Not defined: RegWrite_o = valid_o & mainWB[WB_W-1] only. Register-file zero handling is left to the register file.

## Structure
- Shared package memwb_pkg: state enum (EMPTY, FULL, SKID); occupancy constants; a packed payload struct built from parameter widths, or a PAYLOAD_W localparam = WB_W+2*DATA_W+RD_W.
- One sub-module, memwb_payload_reg: enable-loaded PAYLOAD_W register with async active-low clear. Instantiated twice (main, skid).

## Test plan
- Reset, then stream 4 entries (RDaddr 1..4, ALUout 0x10..0x13) with ready_i=1 → outputs one cycle later, back-to-back; valid_o stays 1; occ_o=1.
- Hold ready_i=0 while sending RDaddr 5, 6 → occ_o=2, ready_o=0. Release ready_i → outputs 5 then 6 in order; ready_o returns to 1 after the first take.
- flush_i in SKID with valid_i=1 (RDaddr 7) → next cycle valid_o=0, RegWrite_o=0, occ_o=0. Entry 7 never appears.
- Entry WB_i=2'b11, Data_i=0xDEADBEEF, RDaddr 0 → with MEMWB_X0_SUPPRESS_EN RegWrite_o=0; without it RegWrite_o=1, MemtoReg_o=1.
- Assert rst_n_i low mid-cycle while in FULL → outputs zero immediately without waiting for a clock edge; ready_o=1.
- Parameter sweep DATA_W=64, RD_W=6, WB_W=3 with WB_i=3'b101 → RegWrite_o=1, MemtoReg_o=1, 64-bit data intact.
